fibonacci_arbiter: RTL and testbench

Shares one fibonacci engine (ports clk, reset, din[15:0], start, dout[15:0], done) between NUM_REQ requesters.
- Accepts requests, picks one round-robin, and runs it to completion on the engine.
- Each job is sequenced as: engine reset pulse, then start pulse, then wait for done.
- Returns each result tagged with the requester id.
- A watchdog aborts jobs whose done never arrives.

---
 rtl/fibonacci_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_fibonacci_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fibonacci_arbiter.sv
// Round-robin arbiter sharing one fibonacci engine between NUM_REQ requesters.
// Each job runs engine reset, start and done-wait, guarded by a watchdog; results come back tagged with the requester id.
module fibonacci_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int ID_WIDTH      = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_din,
  output logic [NUM_REQ-1:0]              ack,
  output logic                            resp_valid,
  output logic [ID_WIDTH-1:0]             resp_id,
  output logic [DATA_WIDTH-1:0]           resp_dout,
  output logic                            resp_err,
  output logic                            busy,
  output logic                            fib_reset,
  output logic [DATA_WIDTH-1:0]           fib_din,
  output logic                            fib_start,
  input  logic [DATA_WIDTH-1:0]           fib_dout,
  input  logic                            fib_done
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ID_WIDTH-1:0]     r_rr;
  logic [ID_WIDTH-1:0]     r_job_id;
  logic [DATA_WIDTH-1:0]   r_job_din;
  logic [CNT_W-1:0]        r_cnt;
  logic                    w_win_found;
  logic [ID_WIDTH-1:0]     w_win_id;
  logic                    w_timeout;
  logic                    w_wait_exit;

  logic [NUM_REQ-1:0]      r_ack;
  logic                    r_resp_valid;
  logic [ID_WIDTH-1:0]     r_resp_id;
  logic [DATA_WIDTH-1:0]   r_resp_dout;
  logic                    r_resp_err;
  logic                    r_busy;
  logic [DATA_WIDTH-1:0]   r_fib_din;
  logic                    r_fib_start;

  // First set request bit scanning upward from ptr, wrapping modulo NUM_REQ; MSB is the found flag.
  function automatic logic [ID_WIDTH:0] pick_winner(input logic [NUM_REQ-1:0] reqv,
                                                    input logic [ID_WIDTH-1:0] ptr);
    logic                found;
    logic [ID_WIDTH-1:0] id;
    int                  idx;
    found = 1'b0;
    id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && reqv[idx]) begin
        found = 1'b1;
        id    = ID_WIDTH'(idx);
      end
    end
    return {found, id};
  endfunction

  // Round-robin winner selection from the live request vector.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    {w_win_found, w_win_id} = pick_winner(req, r_rr);
  end

  // Next-state logic; a done arriving on the timeout cycle still counts as success.
  always_comb begin
    w_state_next = r_state;
    w_timeout    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    w_wait_exit  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_state_next = S_RST;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RST:   w_state_next = S_START;
      S_START: w_state_next = S_WAIT;
      S_WAIT: begin
        if (fib_done || w_timeout) begin
          w_state_next = S_RESP;
          w_wait_exit  = 1'b1;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Job latch, round-robin pointer and watchdog counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr      <= '0;
      r_job_id  <= '0;
      r_job_din <= '0;
      r_cnt     <= '0;
    end else begin
      if (r_state == S_IDLE && w_win_found) begin
        r_job_id  <= w_win_id;
        r_job_din <= req_din[w_win_id*DATA_WIDTH +: DATA_WIDTH];
      end
      if (r_state == S_RESP) begin
        if (r_job_id == ID_WIDTH'(NUM_REQ - 1)) begin
          r_rr <= '0;
        end else begin
          r_rr <= r_job_id + ID_WIDTH'(1);
        end
      end
      // Counter wraps harmlessly on the last WAIT cycle; it is cleared outside WAIT.
      if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Registered outputs, each loaded from the transition into the state that shows it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_dout  <= '0;
      r_resp_err   <= 1'b0;
      r_busy       <= 1'b0;
      r_fib_din    <= '0;
      r_fib_start  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_win_found) begin
        r_ack <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_id;
      end else begin
        r_ack <= '0;
      end
      r_busy       <= (w_state_next != S_IDLE);
      r_fib_start  <= (w_state_next == S_START);
      if (w_state_next == S_START) begin
        r_fib_din <= r_job_din;
      end
      r_resp_valid <= (r_state == S_WAIT) && w_wait_exit;
      if (r_state == S_WAIT && w_wait_exit) begin
        r_resp_id <= r_job_id;
        if (fib_done) begin
          r_resp_dout <= fib_dout;
          r_resp_err  <= 1'b0;
        end else begin
          r_resp_dout <= '0;
          r_resp_err  <= 1'b1;
        end
      end
    end
  end

  assign ack        = r_ack;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_dout  = r_resp_dout;
  assign resp_err   = r_resp_err;
  assign busy       = r_busy;
  assign fib_din    = r_fib_din;
  assign fib_start  = r_fib_start;
  assign fib_reset  = reset | (r_state == S_RST);

endmodule

// File: tb/tb_fibonacci_arbiter.sv
// Directed and randomized bench for fibonacci_arbiter with a behavioural fibonacci engine
// and a round-robin reference model kept at the level of request vectors and ids.
module tb_fibonacci_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int TO = 16;

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_din;
  logic [NR-1:0]     ack;
  logic              resp_valid;
  logic [1:0]        resp_id;
  logic [DW-1:0]     resp_dout;
  logic              resp_err;
  logic              busy;
  logic              fib_reset;
  logic [DW-1:0]     fib_din;
  logic              fib_start;
  logic [DW-1:0]     fib_dout;
  logic              fib_done;

  int n_checks = 0;
  int n_err    = 0;
  int m_rr     = 0;
  logic [DW-1:0] m_din [NR];

  int            eng_lat;
  int            eng_cnt;
  logic [DW-1:0] eng_n;

  fibonacci_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_din(req_din), .ack(ack),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_dout(resp_dout),
    .resp_err(resp_err), .busy(busy), .fib_reset(fib_reset), .fib_din(fib_din),
    .fib_start(fib_start), .fib_dout(fib_dout), .fib_done(fib_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fib_ref(input int n);
    int a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return DW'(a);
  endfunction

  // Engine: done rises lat cycles after start is sampled (lat=0: never), cleared by fib_reset.
  always @(posedge clk) begin
    if (fib_reset) begin
      fib_done <= 1'b0;
      eng_cnt  <= 0;
    end else if (fib_start) begin
      eng_n <= fib_din;
      if (eng_lat == 1) begin
        fib_done <= 1'b1;
        fib_dout <= fib_ref(int'(fib_din));
        eng_cnt  <= 0;
      end else begin
        fib_done <= 1'b0;
        eng_cnt  <= (eng_lat == 0) ? 0 : eng_lat - 1;
      end
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        fib_done <= 1'b1;
        fib_dout <= fib_ref(int'(eng_n));
      end
    end
  end

  function automatic int model_pick(input logic [NR-1:0] r, input int ptr);
    int win;
    win = -1;
    for (int k = 0; k < NR; k++) begin
      if (win < 0 && r[(ptr + k) % NR]) win = (ptr + k) % NR;
    end
    return win;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] n);
    req[i] = 1'b1;
    req_din[i*DW +: DW] = n;
    m_din[i] = n;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_rr  = 0;
  endtask

  // One job from the IDLE cycle that sees req through the cycle after RESP.
  task automatic serve(input int id, input logic [DW-1:0] din, input logic [DW-1:0] dout,
                       input logic err, input int exp_wait, input bit hold);
    int waited;
    chk("idle_busy", 32'(busy), 32'd0);
    tick();
    chk("ack", 32'(ack), 32'(4'b0001 << id));
    chk("rst_pulse", 32'(fib_reset), 32'd1);
    chk("busy", 32'(busy), 32'd1);
    if (!hold) req[id] = 1'b0;
    tick();
    chk("start", 32'(fib_start), 32'd1);
    chk("start_din", 32'(fib_din), 32'(din));
    chk("ack_once", 32'(ack), 32'd0);
    chk("rst_done", 32'(fib_reset), 32'd0);
    tick();
    waited = 0;
    while (!resp_valid && waited < 40) begin
      tick();
      waited++;
    end
    chk("wait_len", 32'(waited), 32'(exp_wait));
    chk("resp_id", 32'(resp_id), 32'(id));
    chk("resp_dout", 32'(resp_dout), 32'(dout));
    chk("resp_err", 32'(resp_err), 32'(err));
    chk("din_hold", 32'(fib_din), 32'(din));
    m_rr = (id + 1) % NR;
    tick();
    chk("resp_pulse", 32'(resp_valid), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int id, lat, expw;
    logic e;
    logic [DW-1:0] n;
    reset   = 1'b1;
    req     = '0;
    req_din = '0;
    eng_lat = 3;
    eng_cnt = 0;
    for (int i = 0; i < NR; i++) m_din[i] = '0;
    repeat (3) tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rv", 32'(resp_valid), 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    chk("rst_dout", 32'(resp_dout), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(fib_start), 32'd0);
    chk("rst_din", 32'(fib_din), 32'd0);
    chk("rst_fibrst", 32'(fib_reset), 32'd1);
    reset = 1'b0;
    tick();
    chk("idle_fibrst", 32'(fib_reset), 32'd0);

    // Single job
    set_req(0, 16'd5);
    serve(0, 16'd5, 16'd5, 1'b0, 3, 1'b0);

    // All four requesting, each dropped after its ack
    do_reset();
    set_req(0, 16'd5); set_req(1, 16'd6); set_req(2, 16'd12); set_req(3, 16'd1);
    serve(0, 16'd5, 16'd5, 1'b0, 3, 1'b0);
    serve(1, 16'd6, 16'd8, 1'b0, 3, 1'b0);
    serve(2, 16'd12, 16'd144, 1'b0, 3, 1'b0);
    serve(3, 16'd1, 16'd1, 1'b0, 3, 1'b0);

    // Two held requesters alternate
    do_reset();
    set_req(0, 16'd6); set_req(2, 16'd6);
    serve(0, 16'd6, 16'd8, 1'b0, 3, 1'b1);
    serve(2, 16'd6, 16'd8, 1'b0, 3, 1'b1);
    serve(0, 16'd6, 16'd8, 1'b0, 3, 1'b1);
    serve(2, 16'd6, 16'd8, 1'b0, 3, 1'b1);
    req = '0;

    // Watchdog timeout, then a working job
    eng_lat = 0;
    set_req(1, 16'd7);
    serve(1, 16'd7, 16'd0, 1'b1, TO, 1'b0);
    eng_lat = 3;
    set_req(3, 16'd12);
    serve(3, 16'd12, 16'd144, 1'b0, 3, 1'b0);

    // Reset during WAIT drops the job
    eng_lat = 10;
    set_req(2, 16'd9);
    tick();
    req[2] = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("mid_ack", 32'(ack), 32'd0);
    chk("mid_rv", 32'(resp_valid), 32'd0);
    chk("mid_id", 32'(resp_id), 32'd0);
    chk("mid_dout", 32'(resp_dout), 32'd0);
    chk("mid_err", 32'(resp_err), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_start", 32'(fib_start), 32'd0);
    chk("mid_din", 32'(fib_din), 32'd0);
    chk("mid_fibrst", 32'(fib_reset), 32'd1);
    reset = 1'b0;
    m_rr  = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("dropped_rv", 32'(resp_valid), 32'd0);
    end
    eng_lat = 3;
    set_req(1, 16'd6);
    serve(1, 16'd6, 16'd8, 1'b0, 3, 1'b0);

    // Done on the very last WAIT cycle beats the timeout
    eng_lat = TO;
    set_req(0, 16'd12);
    serve(0, 16'd12, 16'd144, 1'b0, TO, 1'b0);

    // Randomized jobs against the round-robin model
    for (int j = 0; j < 16; j++) begin
      if (req == '0) begin
        set_req($urandom_range(0, NR - 1), DW'($urandom_range(1, 24)));
      end
      id   = model_pick(req, m_rr);
      lat  = $urandom_range(1, 20);
      e    = (lat > TO);
      expw = e ? TO : lat;
      n    = m_din[id];
      eng_lat = lat;
      serve(id, n, e ? 16'd0 : fib_ref(int'(n)), e, expw, 1'b0);
      for (int k = 0; k < NR; k++) begin
        if (!req[k] && ($urandom_range(0, 2) == 0)) set_req(k, DW'($urandom_range(1, 24)));
      end
    end
    req = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
